// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline widths and memory-stage state type
package cpu_pkg;

  localparam int CPU_DATA_W  = 16;
  localparam int CPU_ADDR_W  = 16;
  localparam int CPU_WA_W    = 5;
  localparam int MEM_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - BUSY-cycle counter flagging the last cycle an ack may arrive
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count holds completed no-ack BUSY cycles, so the request spans TIMEOUT-1 cycles in total.
  assign tc_o = (cnt_q == CW'(TIMEOUT - 2));

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - CPU memory stage: dmem req/ack access, upstream stall, writeback, timeout abort
module mem_stage_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int WA_W    = CPU_WA_W,
  parameter int TIMEOUT = MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mem_bypass_in,
  input  logic              mem_we_in,
  input  logic              mux_in,
  input  logic [ADDR_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] rd2_in,
  input  logic [WA_W-1:0]   wa_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [WA_W-1:0]   wb_wa,
  output logic              mem_err
);

  mem_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mux_q, mux_d;
  logic [WA_W-1:0]   wa_q, wa_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [WA_W-1:0]   wb_wa_q, wb_wa_d;
  logic              err_q, err_d;
  logic              stall_c;
  logic              busy, tc;

  assign busy = (state_q == BUSY);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!busy),
    .en_i  (busy && !dmem_ack),
    .tc_o  (tc)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mux_d      = mux_q;
    wa_d       = wa_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_wa_d    = wb_wa_q;
    err_d      = 1'b0;
    stall_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_bypass_in) begin
            wb_valid_d = 1'b1;
            wb_data_d  = DATA_W'(alu_res_in);
            wb_wa_d    = wa_in;
          end else begin
            addr_d  = alu_res_in;
            wdata_d = rd2_in;
            we_d    = mem_we_in;
            mux_d   = mux_in;
            wa_d    = wa_in;
            req_d   = 1'b1;
            state_d = BUSY;
            stall_c = 1'b1;
          end
        end
      end
      BUSY: begin
        // An ack on the terminal cycle still completes the access normally.
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = mux_q ? dmem_rdata : DATA_W'(addr_q);
            wb_wa_d    = wa_q;
          end
        end else if (tc) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mux_q      <= 1'b0;
      wa_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_wa_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mux_q      <= mux_d;
      wa_q       <= wa_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_wa_q    <= wb_wa_d;
      err_q      <= err_d;
    end
  end

  // Gated by reset so upstream is released the instant reset asserts.
  assign stall_out  = rst & stall_c;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign wb_wa      = wb_wa_q;
  assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - randomized self-checking bench for mem_stage_unit
module tb_mem_stage_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, mem_bypass_in, mem_we_in, mux_in;
  logic [15:0] alu_res_in, rd2_in;
  logic [4:0]  wa_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [4:0]  wb_wa;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  bit          pend_wb, pend_err;
  logic [15:0] m_data;
  logic [4:0]  m_wa;

  mem_stage_unit #(.TIMEOUT(T)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .mem_bypass_in (mem_bypass_in),
    .mem_we_in     (mem_we_in),
    .mux_in        (mux_in),
    .alu_res_in    (alu_res_in),
    .rd2_in        (rd2_in),
    .wa_in         (wa_in),
    .stall_out     (stall_out),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_wa         (wb_wa),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outcome of the previously completed instruction, visible one cycle after completion.
  task automatic check_outcome();
    chk("wb_valid", 32'(wb_valid), 32'(pend_wb));
    chk("mem_err", 32'(mem_err), 32'(pend_err));
    chk("wb_data", 32'(wb_data), 32'(m_data));
    chk("wb_wa", 32'(wb_wa), 32'(m_wa));
    chk("req_low", 32'(dmem_req), 32'd0);
    pend_wb  = 1'b0;
    pend_err = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid      = 1'b0;
    mem_bypass_in = 1'($urandom);
    mem_we_in     = 1'($urandom);
    mux_in        = 1'($urandom);
    alu_res_in    = 16'($urandom);
    rd2_in        = 16'($urandom);
    wa_in         = 5'($urandom);
    dmem_ack      = 1'($urandom);
    dmem_rdata    = 16'($urandom);
    @(negedge clk);
    check_outcome();
    chk("stall_idle", 32'(stall_out), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // d = BUSY cycles without ack before the ack; d > T-2 never acks in time.
  task automatic exec(input bit byp, input bit we, input bit mux, input logic [15:0] alu,
                      input logic [15:0] rd2, input logic [4:0] wa, input int d,
                      input logic [15:0] rdata);
    int n_exp;
    int cyc;
    bit done;
    bit tout;
    n_exp = byp ? 1 : 1 + ((d + 1 < T - 1) ? d + 1 : T - 1);
    tout  = !byp && (d > T - 2);
    cyc   = 0;
    done  = 1'b0;
    do begin
      cyc++;
      in_valid      = 1'b1;
      mem_bypass_in = byp;
      mem_we_in     = we;
      mux_in        = mux;
      if (cyc == 1) begin
        alu_res_in = alu;
        rd2_in     = rd2;
        wa_in      = wa;
        dmem_ack   = 1'($urandom);
      end else begin
        alu_res_in = 16'($urandom);
        rd2_in     = 16'($urandom);
        wa_in      = 5'($urandom);
        dmem_ack   = (cyc == d + 2);
      end
      dmem_rdata = (cyc == d + 2) ? rdata : 16'($urandom);
      @(negedge clk);
      if (cyc == 1) check_outcome();
      if (cyc >= 2) begin
        chk("req_busy", 32'(dmem_req), 32'd1);
        chk("dmem_we", 32'(dmem_we), 32'(we));
        chk("dmem_addr", 32'(dmem_addr), 32'(alu));
        chk("dmem_wdata", 32'(dmem_wdata), 32'(rd2));
      end
      if (!stall_out) done = 1'b1;
      @(posedge clk);
      #1;
    end while (!done && cyc < T + 4);
    chk("latency", 32'(cyc), 32'(n_exp));
    if (byp) begin
      pend_wb = 1'b1;
      m_data  = alu;
      m_wa    = wa;
    end else if (tout) begin
      pend_err = 1'b1;
    end else if (!we) begin
      pend_wb = 1'b1;
      m_data  = mux ? rdata : alu;
      m_wa    = wa;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_addr"}, 32'(dmem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(dmem_wdata), 32'd0);
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wbd"}, 32'(wb_data), 32'd0);
    chk({tag, "_wbwa"}, 32'(wb_wa), 32'd0);
    chk({tag, "_err"}, 32'(mem_err), 32'd0);
  endtask

  task automatic reset_mid();
    in_valid      = 1'b1;
    mem_bypass_in = 1'b0;
    mem_we_in     = 1'b0;
    mux_in        = 1'b1;
    alu_res_in    = 16'h0ABC;
    rd2_in        = 16'h1357;
    wa_in         = 5'd7;
    dmem_ack      = 1'b0;
    @(negedge clk);
    check_outcome();
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    m_data   = '0;
    m_wa     = '0;
    pend_wb  = 1'b0;
    pend_err = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    in_valid      = 1'b0;
    mem_bypass_in = 1'b0;
    mem_we_in     = 1'b0;
    mux_in        = 1'b0;
    alu_res_in    = '0;
    rd2_in        = '0;
    wa_in         = '0;
    dmem_ack      = 1'b0;
    dmem_rdata    = '0;
    pend_wb       = 1'b0;
    pend_err      = 1'b0;
    m_data        = '0;
    m_wa          = '0;
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    exec(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 5'd3, 0, 16'h0000);
    exec(1'b0, 1'b0, 1'b1, 16'h0040, 16'h1111, 5'd5, 3, 16'hBEEF);
    exec(1'b0, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 5'd2, 1, 16'h0000);
    idle_cycle();
    exec(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 5'd9, T, 16'h5555);
    exec(1'b0, 1'b0, 1'b1, 16'h0104, 16'h0000, 5'd10, T - 2, 16'h6666);
    idle_cycle();
    reset_mid();
    exec(1'b0, 1'b0, 1'b1, 16'h0200, 16'h0000, 5'd11, 0, 16'hC0DE);
    exec(1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 5'd12, 0, 16'h0000);
    exec(1'b0, 1'b1, 1'b0, 16'h0208, 16'h4242, 5'd13, 0, 16'h0000);
    idle_cycle();

    repeat (200) begin
      bit   byp, we, mux;
      int   d;
      byp = ($urandom_range(0, 2) == 0);
      we  = 1'($urandom);
      mux = 1'($urandom);
      d   = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 3, T + 1) : $urandom_range(0, 4);
      exec(byp, we, mux, 16'($urandom), 16'($urandom), 5'($urandom), d, 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
